// File: rtl/mips_memory_stage_access_if.sv
// mips_memory_stage_access_if: data-bus req/ack port between the memory stage and memory
interface mips_memory_stage_access_if #(parameter int ADDR_WIDTH = 32);
    logic req;
    logic we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0] strobe;
    logic [31:0] wdata;
    logic ack;
    logic [31:0] rdata;
    modport master(output req, we, addr, strobe, wdata, input ack, rdata);
    modport slave(input req, we, addr, strobe, wdata, output ack, rdata);
endinterface

// File: rtl/mips_memory_stage_access.sv
// mips_memory_stage_access: one bus transaction per memory op, with load extension, stall and fault reporting
module mips_memory_stage_access #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_write_enable,
    input  logic [1:0] in_byte_enable,
    input  logic in_load_unsigned,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [31:0] in_store_data,
    mips_memory_stage_access_if.master bus,
    output logic out_valid,
    output logic [31:0] out_data,
    output logic out_fault
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [0:0] state;
    logic [CW-1:0] cnt;
    logic [1:0] be_q;
    logic [1:0] lo_q;
    logic uns_q;
    logic misaligned;
    logic [3:0] strobe_next;
    logic [31:0] wdata_next;
    logic [31:0] rdata_sh;
    logic [31:0] load_data;

    always_comb begin
        in_ready = state == IDLE && !reset;
        misaligned = (in_byte_enable == 2'd2 && in_addr[0]) || (in_byte_enable == 2'd3 && in_addr[1:0] != 2'b00);
        strobe_next = in_byte_enable == 2'd1 ? 4'b0001 << in_addr[1:0] :
                      in_byte_enable == 2'd2 ? (in_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_next = in_byte_enable == 2'd1 ? {4{in_store_data[7:0]}} :
                     in_byte_enable == 2'd2 ? {2{in_store_data[15:0]}} : in_store_data;
        // Lane select uses the latched byte offset, since bus.addr is word-aligned
        rdata_sh = bus.rdata >> {lo_q, 3'b000};
        load_data = be_q == 2'd1 ? {{24{!uns_q && rdata_sh[7]}}, rdata_sh[7:0]} :
                    be_q == 2'd2 ? {{16{!uns_q && rdata_sh[15]}}, rdata_sh[15:0]} : bus.rdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            be_q <= '0;
            lo_q <= '0;
            uns_q <= 1'b0;
            bus.req <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= '0;
            bus.strobe <= '0;
            bus.wdata <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_fault <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    if (in_byte_enable == 2'd0) begin
                        out_valid <= 1'b1;
                        out_data <= 32'(in_addr);
                        out_fault <= 1'b0;
                    end else if (misaligned) begin
                        out_valid <= 1'b1;
                        out_data <= '0;
                        out_fault <= 1'b1;
                    end else begin
                        state <= BUSY;
                        cnt <= '0;
                        be_q <= in_byte_enable;
                        lo_q <= in_addr[1:0];
                        uns_q <= in_load_unsigned;
                        bus.req <= 1'b1;
                        bus.we <= in_write_enable;
                        bus.addr <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.strobe <= strobe_next;
                        bus.wdata <= wdata_next;
                    end
                end
            end else if (bus.ack) begin
                state <= IDLE;
                bus.req <= 1'b0;
                out_valid <= 1'b1;
                out_data <= bus.we ? 32'd0 : load_data;
                out_fault <= 1'b0;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                bus.req <= 1'b0;
                out_valid <= 1'b1;
                out_data <= '0;
                out_fault <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: doc/mips_memory_stage_access.md
Name: mips_memory_stage_access

Overview:
Memory-stage access unit, directly downstream of the memory control-signal generator. Consumes its write-enable / byte-enable control plus the ALU address and store data. Runs one data-bus transaction per memory instruction with a req/ack handshake, and generates byte strobes and lane-replicated store data. Aligns and extends load data, stalls the pipeline while a transaction is in flight, and reports misaligned or timed-out accesses as faults.

Parameters:
ADDR_WIDTH, 32, byte-address width; bus_addr carries the word-aligned form.
TIMEOUT_CYCLES, 255, maximum cycles bus_req is held without bus_ack before a fault is raised; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  instruction present at memory-stage input
in_ready  output  1  stage accepts input this cycle; high only in IDLE and with reset low
in_write_enable  input  1  control writeEnable (1 = store)
in_byte_enable  input  2  control byteEnable: 0 None, 1 Byte, 2 Half, 3 Int
in_load_unsigned  input  1  1 = zero-extend load (lbu/lhu)
in_addr  input  ADDR_WIDTH  ALU result; byte address for memory ops, passthrough value otherwise
in_store_data  input  32  rt value for stores
bus_req  output  1  transaction request
bus_we  output  1  write transaction
bus_addr  output  ADDR_WIDTH  in_addr with bits [1:0] forced to 0
bus_strobe  output  4  byte-lane enables, lane 0 = bits [7:0]
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  transaction complete; bus_rdata valid for reads
bus_rdata  input  32  read word
out_valid  output  1  one-cycle result pulse
out_data  output  32  extended load data, or passthrough in_addr
out_fault  output  1  qualifies out_valid: misaligned or timeout

Behaviour:
- States: IDLE, BUSY. Accept = in_valid && in_ready. Upstream holds inputs stable while in_ready is low.
- Reset, and every cycle reset is high: state IDLE, bus_req/bus_we/bus_strobe/bus_addr/bus_wdata = 0, out_valid/out_fault/out_data = 0, timeout counter = 0, in_ready = 0.
- Reset mid-BUSY: bus_req is 0 the cycle after reset is sampled and the transaction is abandoned. bus_ack arriving in IDLE is ignored.
- Accept with byte_enable None: no bus activity. Next cycle out_valid=1, out_data=in_addr, out_fault=0.
- Alignment check: Half with addr[0]=1, or Int with addr[1:0]!=0, is misaligned. Accepting a misaligned access produces no bus_req; next cycle out_valid=1, out_fault=1, out_data=0. Stores are suppressed.
- Accept aligned access (cycle T): bus outputs are registered. bus_req=1 from T+1, state BUSY, in_ready=0.
- Strobes: Byte gives 1<<addr[1:0]; Half gives 0011 if addr[1]=0, else 1100; Int gives 1111.
- Write data: Byte replicates store_data[7:0] x4; Half replicates [15:0] x2; Int passes through.
- bus_we = in_write_enable. All bus outputs stay stable while bus_req=1.
- bus_ack sampled high in BUSY (cycle A): bus_req=0 at A+1, out_valid=1 at A+1, state IDLE, in_ready=1 at A+1.
- Store completion: out_data=0.
- Load completion: out_data is the selected lane (byte lane addr[1:0], half lane addr[1]). It is sign-extended unless load_unsigned; Int is unmodified.
- Minimum bus latency: a zero-wait ack at T+1 gives out_valid at T+2.
- Timeout: counter increments each BUSY cycle without ack. When bus_req has been high TIMEOUT_CYCLES cycles with no ack, next cycle bus_req=0, out_valid=1, out_fault=1, state IDLE. An ack in the same cycle as expiry wins (normal completion).
- out_valid is exactly one cycle; no downstream backpressure. out_data/out_fault hold until the next out_valid.

Test Plan:
- lw, addr 0x00001000, ack at T+1, rdata 0xDEADBEEF -> bus_req T+1 only, strobe 1111, we=0; out_valid at T+2, out_data 0xDEADBEEF.
- lb addr 0x00000003, rdata 0x80123456 -> strobe 1000, out_data 0xFFFFFF80. Repeat as lbu -> 0x00000080.
- sh addr 0x00000102, store 0x1234ABCD, ack after 3 wait cycles -> strobe 1100, wdata 0xABCDABCD, bus_addr 0x00000100, we=1; bus outputs stable across waits; in_ready low throughout.
- lw addr 0x00000001 -> no bus_req; next cycle out_valid=1, out_fault=1. Same for sh addr 0x00000005.
- lw with no ack, TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, then out_valid=1 with out_fault=1. A later stray ack in IDLE -> no out_valid.
- Reset asserted during BUSY, then ack after reset deasserts -> bus_req 0 the cycle after reset is sampled, no out_valid, in_ready=1 once reset is low.
